// File: rtl/srt_otf_accum_pkg.sv
// Shared divider definitions: FSM states, one-hot digit bit positions and the
// digit decoder used by the on-the-fly quotient converter.
package srt_otf_accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int DIG_M2 = 0;
    localparam int DIG_M1 = 1;
    localparam int DIG_Z  = 2;
    localparam int DIG_P1 = 3;
    localparam int DIG_P2 = 4;

    typedef struct packed {
        logic              illegal;
        logic signed [2:0] value;
    } digit_t;

    // Illegal encodings (not one-hot, or +/-2 in radix-2) decode as digit 0.
    function automatic digit_t decodeDigit(input logic [4:0] oh, input logic radix4);
        digit_t d;
        d.illegal = 1'b0;
        d.value   = 3'sd0;
        if (oh == (5'b1 << DIG_M2))      d.value = -3'sd2;
        else if (oh == (5'b1 << DIG_M1)) d.value = -3'sd1;
        else if (oh == (5'b1 << DIG_Z))  d.value = 3'sd0;
        else if (oh == (5'b1 << DIG_P1)) d.value = 3'sd1;
        else if (oh == (5'b1 << DIG_P2)) d.value = 3'sd2;
        else                             d.illegal = 1'b1;
        if (!radix4 && (d.value == 3'sd2 || d.value == -3'sd2)) begin
            d.illegal = 1'b1;
        end
        if (d.illegal) d.value = 3'sd0;
        return d;
    endfunction

endpackage

// File: rtl/srt_otf_accum_step.sv
// Combinational single-digit on-the-fly conversion step for Q and QM = Q-1.
module srt_otf_step #(
    parameter int WIDTH = 32
) (
    input  logic                    radix4,
    input  logic signed [2:0]       digit,
    input  logic        [WIDTH-1:0] q,
    input  logic        [WIDTH-1:0] qm,
    output logic        [WIDTH-1:0] qNext,
    output logic        [WIDTH-1:0] qmNext
);

    logic        [WIDTH-1:0] qSel;
    logic        [WIDTH-1:0] qmSel;
    logic signed [2:0]       digitM1;

    assign qSel    = (digit >= 3'sd0) ? q : qm;
    assign qmSel   = (digit >  3'sd0) ? q : qm;
    assign digitM1 = digit - 3'sd1;

    // Two's-complement low bits already equal d / 4+d and d-1 / 3+d.
    always_comb begin
        qNext  = '0;
        qmNext = '0;
        if (radix4) begin
            qNext  = {qSel[WIDTH-3:0], digit[1:0]};
            qmNext = {qmSel[WIDTH-3:0], digitM1[1:0]};
        end else begin
            qNext  = {qSel[WIDTH-2:0], digit != 3'sd0};
            qmNext = {qmSel[WIDTH-2:0], digit == 3'sd0};
        end
    end

endmodule

// File: rtl/srt_otf_accum.sv
// On-the-fly SRT quotient accumulator: collects signed digits into Q and Q-1
// with a start/valid-ready/result handshake.
module srt_otf_accum
    import srt_otf_accum_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             radix4,
    input  logic [CNT_W-1:0] num_digits,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_digit_oh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_quotient_minus_one,
    output logic             err_illegal
);

    state_t           state;
    logic [WIDTH-1:0] q, qm, qNext, qmNext;
    logic [CNT_W-1:0] cnt, target, limit, nSat;
    logic             mode, err, inReadyR, outValidR;
    digit_t           dec;

    assign dec   = decodeDigit(in_digit_oh, mode);
    assign limit = radix4 ? CNT_W'(WIDTH >> 1) : CNT_W'(WIDTH);
    assign nSat  = (num_digits > limit) ? limit : num_digits;

    srt_otf_step #(.WIDTH(WIDTH)) uStep (
        .radix4 (mode),
        .digit  (dec.value),
        .q      (q),
        .qm     (qm),
        .qNext  (qNext),
        .qmNext (qmNext)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            q         <= '0;
            qm        <= '0;
            cnt       <= '0;
            target    <= '0;
            mode      <= 1'b0;
            err       <= 1'b0;
            inReadyR  <= 1'b0;
            outValidR <= 1'b0;
        end else if (start) begin
            q      <= '0;
            qm     <= '1;
            err    <= 1'b0;
            cnt    <= '0;
            mode   <= radix4;
            target <= nSat;
            if (nSat == '0) begin
                state     <= DONE;
                inReadyR  <= 1'b0;
                outValidR <= 1'b1;
            end else begin
                state     <= ACCUM;
                inReadyR  <= 1'b1;
                outValidR <= 1'b0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        q   <= qNext;
                        qm  <= qmNext;
                        cnt <= cnt + CNT_W'(1);
                        if (dec.illegal) err <= 1'b1;
                        if (cnt + CNT_W'(1) == target) begin
                            state     <= DONE;
                            inReadyR  <= 1'b0;
                            outValidR <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        outValidR <= 1'b0;
                    end
                end
                IDLE: ;
                default: ;
            endcase
        end
    end

    assign in_ready               = inReadyR;
    assign out_valid              = outValidR;
    assign out_quotient           = q;
    assign out_quotient_minus_one = qm;
    assign err_illegal            = err;

endmodule

// File: tb/tb_srt_otf_accum.sv
// Directed bench for srt_otf_accum at WIDTH=8 with hand-computed Q/QM values.
module tb_srt_otf_accum;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [4:0] OH_M2 = 5'b00001;
    localparam logic [4:0] OH_M1 = 5'b00010;
    localparam logic [4:0] OH_Z  = 5'b00100;
    localparam logic [4:0] OH_P1 = 5'b01000;
    localparam logic [4:0] OH_P2 = 5'b10000;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             radix4 = 1'b0;
    logic [CNT_W-1:0] num_digits = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_digit_oh = 5'b00100;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_quotient_minus_one;
    logic             err_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    srt_otf_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .radix4                 (radix4),
        .num_digits             (num_digits),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_digit_oh            (in_digit_oh),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_quotient           (out_quotient),
        .out_quotient_minus_one (out_quotient_minus_one),
        .err_illegal            (err_illegal)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doStart(input logic r4, input logic [CNT_W-1:0] n);
        start      = 1'b1;
        radix4     = r4;
        num_digits = n;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic sendDigit(input logic [4:0] oh);
        in_valid    = 1'b1;
        in_digit_oh = oh;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [7:0] expQ, input logic [7:0] expQm);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_q"},     64'(out_quotient), 64'(expQ));
        check({tag, "_qm"},    64'(out_quotient_minus_one), 64'(expQm));
    endtask

    initial begin
        @(negedge clock);
        check("rst_q",      64'(out_quotient), 64'h00);
        check("rst_qm",     64'(out_quotient_minus_one), 64'h00);
        check("rst_ready",  64'(in_ready), 64'd0);
        check("rst_valid",  64'(out_valid), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Digits offered before any start must not be accepted.
        sendDigit(OH_P1);
        check("pre_start_q",     64'(out_quotient), 64'h00);
        check("pre_start_ready", 64'(in_ready), 64'd0);

        // Radix-4 +1,+2,-1,0 -> 0x5C / 0x5B.
        out_ready = 1'b0;
        doStart(1'b1, 4'd4);
        check("r4_start_ready", 64'(in_ready), 64'd1);
        check("r4_start_qm",    64'(out_quotient_minus_one), 64'hFF);
        sendDigit(OH_P1);
        sendDigit(OH_P2);
        sendDigit(OH_M1);
        check("r4_not_done_yet", 64'(out_valid), 64'd0);
        check("r4_partial_q",    64'(out_quotient), 64'h17);
        sendDigit(OH_Z);
        checkResult("r4_basic", 8'h5C, 8'h5B);
        check("r4_basic_ready", 64'(in_ready), 64'd0);

        // Radix-2 +1,-1,+1 -> 3 / 2, then hold with out_ready low.
        doStart(1'b0, 4'd3);
        check("r2_restart_valid", 64'(out_valid), 64'd0);
        sendDigit(OH_P1);
        sendDigit(OH_M1);
        sendDigit(OH_P1);
        checkResult("r2_basic", 8'h03, 8'h02);
        check("r2_basic_err", 64'(err_illegal), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkResult("hold", 8'h03, 8'h02);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("drain_valid", 64'(out_valid), 64'd0);
        check("idle_q",      64'(out_quotient), 64'h03);
        check("idle_qm",     64'(out_quotient_minus_one), 64'h02);
        @(negedge clock);
        check("idle_stay_valid", 64'(out_valid), 64'd0);

        // Illegal +2 in radix-2 is processed as 0: +1,0,+1 -> 5 / 4.
        doStart(1'b0, 4'd3);
        sendDigit(OH_P1);
        sendDigit(OH_P2);
        check("ill_a_err_mid", 64'(err_illegal), 64'd1);
        sendDigit(OH_P1);
        checkResult("ill_a", 8'h05, 8'h04);
        check("ill_a_err", 64'(err_illegal), 64'd1);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("ill_a_err_idle", 64'(err_illegal), 64'd1);

        // Non-one-hot code; err must first clear on start.
        doStart(1'b0, 4'd3);
        check("ill_b_err_clear", 64'(err_illegal), 64'd0);
        sendDigit(OH_P1);
        sendDigit(5'b00110);
        sendDigit(OH_P1);
        checkResult("ill_b", 8'h05, 8'h04);
        check("ill_b_err", 64'(err_illegal), 64'd1);

        // Abort after two digits; the start-cycle digit must be ignored.
        doStart(1'b1, 4'd4);
        sendDigit(OH_P1);
        sendDigit(OH_M1);
        in_valid    = 1'b1;
        in_digit_oh = OH_P1;
        doStart(1'b1, 4'd4);
        in_valid = 1'b0;
        check("abort_q",     64'(out_quotient), 64'h00);
        check("abort_qm",    64'(out_quotient_minus_one), 64'hFF);
        check("abort_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) sendDigit(OH_P2);
        checkResult("abort_new", 8'hAA, 8'hA9);

        // num_digits above WIDTH/2 in radix-4 saturates to 4 digits.
        doStart(1'b1, 4'd7);
        for (int i = 0; i < 4; i++) sendDigit(OH_P2);
        checkResult("sat", 8'hAA, 8'hA9);

        // Asynchronous reset mid-conversion with err already set.
        doStart(1'b0, 4'd3);
        sendDigit(OH_P1);
        sendDigit(5'b00000);
        check("pre_rst_err", 64'(err_illegal), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("arst_q",     64'(out_quotient), 64'h00);
        check("arst_qm",    64'(out_quotient_minus_one), 64'h00);
        check("arst_ready", 64'(in_ready), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_err",   64'(err_illegal), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sendDigit(OH_P1);
        check("post_rst_q", 64'(out_quotient), 64'h00);

        // Zero-digit start goes straight to DONE.
        doStart(1'b1, 4'd0);
        checkResult("zero", 8'h00, 8'hFF);
        check("zero_ready", 64'(in_ready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srt_otf_accum.md
SRT_OTF_ACCUM -- requirements
Module: srt_otf_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 32, quotient register width in bits (8..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, width of the digit-count field.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a new conversion.
REQ-006 SHALL have port radix4  input  1  mode sampled at start: 1 = radix-4 (2 bits/digit), 0 = radix-2 (1 bit/digit).
REQ-007 SHALL have port num_digits  input  CNT_W  number of digits to accept, sampled at start.
REQ-008 SHALL have port in_valid  input  1  digit offered.
REQ-009 SHALL have port in_ready  output  1  digit accepted when in_valid && in_ready.
REQ-010 SHALL have port in_digit_oh  input  5  one-hot signed digit; bits 0..4 = -2,-1,0,+1,+2.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port out_quotient  output  WIDTH  converted quotient Q.
REQ-014 SHALL have port out_quotient_minus_one  output  WIDTH  QM = Q-1 mod 2^WIDTH.
REQ-015 SHALL have port err_illegal  output  1  sticky illegal-digit flag.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-017 SHALL, on start in any state, set Q=0, QM=all-ones, clear err_illegal, clear the digit counter and latch radix4 and num_digits; start has priority over every other event in that cycle.
REQ-018 SHALL go from start to ACCUM, or to DONE if num_digits==0.
REQ-019 SHALL drive in_ready=1 only in ACCUM and out_valid=1 only in DONE.
REQ-020 SHALL, on each accepted radix-4 digit d, set Q'={d>=0 ? Q : QM, (d>=0 ? d : 4+d)[1:0]} and QM'={d>0 ? Q : QM, (d>0 ? d-1 : 3+d)[1:0]}.
REQ-021 SHALL, on each accepted radix-2 digit d, set Q'={d>=0 ? Q : QM, d!=0} and QM'={d>0 ? Q : QM, d==0}.
REQ-022 SHALL discard the shifted-out MSBs; WIDTH is held constant.
REQ-023 SHALL leave Q, QM and the counter unchanged in any ACCUM cycle with no handshake.
REQ-024 SHALL flag an illegal digit when in_digit_oh is not exactly one-hot, or when the digit is ±2 in radix-2 mode.
REQ-025 SHALL, on an accepted illegal digit, set err_illegal (held until the next start) and process the digit as 0.
REQ-026 SHALL enter DONE in the cycle after the num_digits-th accepted digit; there is no extra latency.
REQ-027 SHALL hold out_quotient and out_quotient_minus_one stable while out_valid && !out_ready.
REQ-028 SHALL go from DONE to IDLE on out_valid && out_ready.
REQ-029 SHALL keep the outputs showing the last Q/QM while in IDLE.
REQ-030 SHALL silently saturate num_digits values above WIDTH>>(radix4?1:0) to that limit.
REQ-031 SHALL, on start during ACCUM, abort the conversion, accept no digit in that cycle, and restart per REQ-017.

Reset
REQ-032 SHALL, on reset low, immediately force state=IDLE, Q=0, QM=0, counter=0, in_ready=0, out_valid=0, err_illegal=0, independent of clock.
REQ-033 SHALL release reset cleanly: the first start after deassertion behaves per REQ-017, and no digit is accepted before a start.

Structure
REQ-034 SHALL place the FSM state enum, digit one-hot bit indices (DIG_M2..DIG_P2) and the digit-decode function in the shared divider package.
REQ-035 SHALL contain one sub-module, srt_otf_step: combinational single-digit Q/QM update, parametrised by WIDTH, with a radix4 select input; the top holds FSM, counter, registers and handshakes.

Verification
REQ-036 SHALL test: WIDTH=8, radix4, num_digits=4, digits +1,+2,-1,0 back-to-back -> out_quotient=0x5C, out_quotient_minus_one=0x5B, out_valid one cycle after the 4th digit.
REQ-037 SHALL test: WIDTH=8, radix-2, num_digits=3, digits +1,-1,+1 -> Q=0x03, QM=0x02, err_illegal=0.
REQ-038 SHALL test: radix-2 with digit oh=5'b10000, then separately oh=5'b00110 -> err_illegal=1 stays set until next start; Q/QM match the case with digit 0.
REQ-039 SHALL test: completed result with out_ready low for 5 cycles -> out_valid and outputs constant; out_ready high -> IDLE next cycle.
REQ-040 SHALL test: start issued after 2 of 4 digits, then 4 new digits +2,+2,+2,+2 (radix4, WIDTH=8) -> Q=0xAA, QM=0xA9, no residue from the aborted run.
REQ-041 SHALL test: reset asserted mid-ACCUM asynchronously -> outputs zero before the next edge; num_digits=0 start -> DONE with Q=0, QM=0xFF.
